// File: rtl/mdio_master.sv
// Clause 22 MDIO management master: one read or write frame per accepted request,
// MDC generated from the 12.5 MHz clock with MDC_HALF clocks per half-period.
module mdio_master #(
  parameter int MDC_HALF = 3,
  parameter int PRE_LEN  = 32
) (
  input  logic        clk_12m_5_mdio,
  input  logic        reset_n,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_rd,
  input  logic [4:0]  req_phyad,
  input  logic [4:0]  req_regad,
  input  logic [15:0] req_wdata,
  output logic        done,
  output logic [15:0] rd_data,
  output logic        rd_err,
  output logic        mdc,
  output logic        mdio_o,
  output logic        mdio_oe,
  input  logic        mdio_i,
  output logic [2:0]  dbg_state
);

  // Handshake: a request transfers on a rising edge where req_valid and req_ready are both 1.
  typedef enum logic [2:0] {S_IDLE, S_PRE, S_CMD, S_TA, S_DATA, S_DONE} state_t;

  localparam logic [5:0] HALF_LAST = 6'(MDC_HALF - 1);
  localparam logic [5:0] PRE_LAST  = 6'(PRE_LEN - 1);

  state_t      state_q, state_d;
  logic        ready_q, ready_d;
  logic        done_q, done_d;
  logic [15:0] rd_data_q, rd_data_d;
  logic        rd_err_q, rd_err_d;
  logic        mdc_q, mdc_d;
  logic        mdio_o_q, mdio_o_d;
  logic        mdio_oe_q, mdio_oe_d;
  logic [5:0]  half_q, half_d;
  logic [5:0]  bit_q, bit_d;
  logic [31:0] sr_q, sr_d;
  logic [15:0] rx_q, rx_d;
  logic        ta_err_q, ta_err_d;
  logic        rd_q, rd_d;

  always_comb begin
    state_d   = state_q;
    ready_d   = ready_q;
    done_d    = 1'b0;
    rd_data_d = rd_data_q;
    rd_err_d  = rd_err_q;
    mdc_d     = mdc_q;
    mdio_o_d  = mdio_o_q;
    mdio_oe_d = mdio_oe_q;
    half_d    = half_q;
    bit_d     = bit_q;
    sr_d      = sr_q;
    rx_d      = rx_q;
    ta_err_d  = ta_err_q;
    rd_d      = rd_q;
    unique case (state_q)
      S_IDLE: begin
        if (req_valid && ready_q) begin
          ready_d   = 1'b0;
          rd_d      = req_rd;
          sr_d      = {2'b01, (req_rd ? 2'b10 : 2'b01), req_phyad, req_regad, 2'b10, req_wdata};
          half_d    = '0;
          bit_d     = '0;
          mdc_d     = 1'b0;
          mdio_oe_d = 1'b1;
          ta_err_d  = 1'b0;
          rx_d      = '0;
          if (PRE_LEN > 0) begin
            state_d  = S_PRE;
            mdio_o_d = 1'b1;
          end else begin
            state_d  = S_CMD;
            mdio_o_d = 1'b0;
          end
        end
      end
      S_PRE, S_CMD, S_TA, S_DATA: begin
        if (half_q != HALF_LAST) begin
          half_d = half_q + 6'd1;
        end else if (!mdc_q) begin
          // End of low phase: MDC rises here, which is also the PHY sampling point.
          half_d = '0;
          mdc_d  = 1'b1;
          if (state_q == S_TA && bit_q == 6'd1) ta_err_d = mdio_i;
          if (state_q == S_DATA) rx_d = {rx_q[14:0], mdio_i};
        end else begin
          half_d   = '0;
          mdc_d    = 1'b0;
          bit_d    = bit_q + 6'd1;
          sr_d     = {sr_q[30:0], 1'b0};
          mdio_o_d = sr_q[30];
          case (state_q)
            S_PRE: begin
              sr_d     = sr_q;
              mdio_o_d = 1'b1;
              if (bit_q == PRE_LAST) begin
                state_d  = S_CMD;
                bit_d    = '0;
                mdio_o_d = sr_q[31];
              end
            end
            S_CMD: begin
              if (bit_q == 6'd13) begin
                state_d   = S_TA;
                bit_d     = '0;
                mdio_oe_d = !rd_q;
              end
            end
            S_TA: begin
              if (bit_q == 6'd1) begin
                state_d = S_DATA;
                bit_d   = '0;
              end
            end
            default: begin
              if (bit_q == 6'd15) begin
                state_d   = S_DONE;
                bit_d     = '0;
                mdio_oe_d = 1'b0;
                mdio_o_d  = 1'b1;
                done_d    = 1'b1;
                if (rd_q) begin
                  rd_data_d = rx_q;
                  rd_err_d  = ta_err_q;
                end
              end
            end
          endcase
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
        ready_d = 1'b1;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk_12m_5_mdio) begin
    if (!reset_n) begin
      state_q   <= S_IDLE;
      ready_q   <= 1'b1;
      done_q    <= 1'b0;
      rd_data_q <= '0;
      rd_err_q  <= 1'b0;
      mdc_q     <= 1'b0;
      mdio_o_q  <= 1'b1;
      mdio_oe_q <= 1'b0;
      half_q    <= '0;
      bit_q     <= '0;
      sr_q      <= '0;
      rx_q      <= '0;
      ta_err_q  <= 1'b0;
      rd_q      <= 1'b0;
    end else begin
      state_q   <= state_d;
      ready_q   <= ready_d;
      done_q    <= done_d;
      rd_data_q <= rd_data_d;
      rd_err_q  <= rd_err_d;
      mdc_q     <= mdc_d;
      mdio_o_q  <= mdio_o_d;
      mdio_oe_q <= mdio_oe_d;
      half_q    <= half_d;
      bit_q     <= bit_d;
      sr_q      <= sr_d;
      rx_q      <= rx_d;
      ta_err_q  <= ta_err_d;
      rd_q      <= rd_d;
    end
  end

  assign req_ready = ready_q;
  assign done      = done_q;
  assign rd_data   = rd_data_q;
  assign rd_err    = rd_err_q;
  assign mdc       = mdc_q;
  assign mdio_o    = mdio_o_q;
  assign mdio_oe   = mdio_oe_q;
  assign dbg_state = state_q;

endmodule

// File: tb/tb_mdio_master.sv
// Bench for mdio_master: timeline model of the frame checked every cycle, plus
// directed transactions with hand-computed bit patterns and completion cycles.
module tb_mdio_master;
  localparam int H  = 3;
  localparam int P  = 32;
  localparam int NB = P + 32;
  localparam int N  = NB * 2 * H;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  logic        reset_n = 1'b0;
  logic        req_valid = 1'b0, req_valid2 = 1'b0;
  logic        req_rd = 1'b0;
  logic [4:0]  req_phyad = '0, req_regad = '0;
  logic [15:0] req_wdata = '0;
  logic        mdio_i = 1'b1;
  logic        mdio_i2 = 1'b1;

  logic        req_ready, done, rd_err, mdc, mdio_o, mdio_oe;
  logic [15:0] rd_data;
  logic [2:0]  dbg_state;
  logic        req_ready2, done2, rd_err2, mdc2, mdio_o2, mdio_oe2;
  logic [15:0] rd_data2;
  logic [2:0]  dbg_state2;

  mdio_master dut (
    .clk_12m_5_mdio(clk), .reset_n(reset_n), .req_valid(req_valid), .req_ready(req_ready),
    .req_rd(req_rd), .req_phyad(req_phyad), .req_regad(req_regad), .req_wdata(req_wdata),
    .done(done), .rd_data(rd_data), .rd_err(rd_err), .mdc(mdc), .mdio_o(mdio_o),
    .mdio_oe(mdio_oe), .mdio_i(mdio_i), .dbg_state(dbg_state)
  );

  mdio_master #(.MDC_HALF(2), .PRE_LEN(0)) dut2 (
    .clk_12m_5_mdio(clk), .reset_n(reset_n), .req_valid(req_valid2), .req_ready(req_ready2),
    .req_rd(req_rd), .req_phyad(req_phyad), .req_regad(req_regad), .req_wdata(req_wdata),
    .done(done2), .rd_data(rd_data2), .rd_err(rd_err2), .mdc(mdc2), .mdio_o(mdio_o2),
    .mdio_oe(mdio_oe2), .mdio_i(mdio_i2), .dbg_state(dbg_state2)
  );

  // ---------------- scoreboard ----------------
  int tests = 0;
  int fails = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h at cycle %0d", name, act, exp, cyc);
    end
  endtask

  task automatic timeout(input string name);
    tests++;
    fails++;
    $display("FAIL %s: no response within bound at cycle %0d", name, cyc);
  endtask

  // Model: one frame is N cycles of bits (2*H clocks each, low half first), then one done cycle.
  bit          chk_en = 1'b0;
  bit          m_active = 1'b0;
  int          m_k = 0;
  logic [NB-1:0] m_frame = '0;
  bit          m_rd = 1'b0;
  bit          m_phy = 1'b0;
  logic [15:0] m_phy_data = '0;
  logic [15:0] m_rd_data = '0;
  bit          m_rd_err = 1'b0;
  logic [15:0] exp_q[$];
  bit          phy_present = 1'b0;
  logic [15:0] phy_data = '0;

  always @(posedge clk) begin
    if (!reset_n) begin
      m_active  = 1'b0;
      m_rd_data = '0;
      m_rd_err  = 1'b0;
      exp_q.delete();
    end else if (m_active) begin
      m_k++;
      if (m_k == N + 1 && m_rd) begin
        m_rd_data = exp_q.pop_front();
        m_rd_err  = !m_phy;
      end
      if (m_k == N + 2) m_active = 1'b0;
    end else if (req_valid) begin
      m_active   = 1'b1;
      m_k        = 1;
      m_rd       = req_rd;
      m_phy      = phy_present;
      m_phy_data = phy_data;
      m_frame    = {{P{1'b1}}, 2'b01, (req_rd ? 2'b10 : 2'b01), req_phyad, req_regad, 2'b10, req_wdata};
      if (req_rd) exp_q.push_back(phy_present ? phy_data : 16'hFFFF);
    end
  end

  bit cap_o[$];
  bit cap_oe[$];
  bit prev_mdc = 1'b0;

  always @(negedge clk) begin : compare
    int t, b;
    bit e_mdc, e_o, e_oe, e_done, e_ready;
    if (chk_en) begin
      t = 0; b = 0;
      e_mdc = 1'b0; e_o = 1'b1; e_oe = 1'b0; e_done = 1'b0; e_ready = 1'b1;
      if (m_active) begin
        e_ready = 1'b0;
        if (m_k <= N) begin
          t     = m_k - 1;
          b     = t / (2 * H);
          e_mdc = (t % (2 * H)) >= H;
          e_oe  = !(m_rd && b >= P + 14);
          e_o   = m_frame[NB-1-b];
        end else begin
          e_done = 1'b1;
        end
      end
      chk("req_ready", req_ready, e_ready);
      chk("done", done, e_done);
      chk("mdc", mdc, e_mdc);
      chk("mdio_oe", mdio_oe, e_oe);
      if (e_oe || !m_active) chk("mdio_o", mdio_o, e_o);
      chk("rd_data", rd_data, m_rd_data);
      if (e_done && m_rd) chk("rd_err", rd_err, m_rd_err);
      // PHY: releases the bus on the first TA bit, drives 0 on the second, then data MSB first
      mdio_i = 1'b1;
      if (m_active && m_k <= N && m_rd && m_phy) begin
        if (b == P + 15) mdio_i = 1'b0;
        else if (b >= P + 16) mdio_i = m_phy_data[15-(b-P-16)];
      end
      if (mdc && !prev_mdc) begin
        cap_o.push_back(mdio_o);
        cap_oe.push_back(mdio_oe);
      end
      prev_mdc = mdc;
    end
  end

  bit cap2_o[$];
  bit cap2_oe[$];
  int rise2_q[$];
  bit prev_mdc2 = 1'b0;

  always @(negedge clk) begin
    if (chk_en) begin
      if (mdc2 && !prev_mdc2) begin
        cap2_o.push_back(mdio_o2);
        cap2_oe.push_back(mdio_oe2);
        rise2_q.push_back(cyc);
      end
      prev_mdc2 = mdc2;
    end
  end

  // ---------------- driver tasks ----------------
  int accept_cyc = 0;

  task automatic start_req(input bit rd, input logic [4:0] pa, input logic [4:0] ra,
                           input logic [15:0] wd, input bit hold);
    int n;
    @(posedge clk); #2;
    cap_o.delete();
    cap_oe.delete();
    req_rd = rd; req_phyad = pa; req_regad = ra; req_wdata = wd;
    req_valid = 1'b1;
    n = 0;
    while (!req_ready && n < 1000) begin
      @(posedge clk); #2;
      n++;
    end
    if (n >= 1000) timeout("accept");
    @(posedge clk); #1;
    accept_cyc = cyc;
    #1;
    if (!hold) req_valid = 1'b0;
  endtask

  task automatic wait_done(output int rel);
    int n;
    rel = -1;
    n = 0;
    while (rel < 0 && n < 2000) begin
      @(negedge clk);
      if (done === 1'b1) rel = cyc - accept_cyc + 1;
      n++;
    end
    if (rel < 0) timeout("done");
  endtask

  task automatic get_cap(output logic [63:0] v, output int n_bits, output int n_oe);
    v = '0;
    n_oe = 0;
    n_bits = cap_o.size();
    for (int i = 0; i < cap_o.size(); i++) begin
      v = {v[62:0], cap_o[i]};
      if (cap_oe[i]) n_oe++;
    end
  endtask

  // ---------------- directed tests ----------------
  initial begin
    int rel, rel2, d1, rise, rdy_cnt, n_bits, n_oe, dcnt, a2;
    logic [63:0] v;
    logic [31:0] v2;

    repeat (3) @(posedge clk);
    #2 reset_n = 1'b1;
    @(negedge clk);
    chk("rst_ready", req_ready, 1'b1);
    chk("rst_done", done, 1'b0);
    chk("rst_mdc", mdc, 1'b0);
    chk("rst_oe", mdio_oe, 1'b0);
    chk("rst_o", mdio_o, 1'b1);
    chk("rst_rd_data", rd_data, 16'h0000);
    chk("rst_rd_err", rd_err, 1'b0);
    chk("rst_state", dbg_state, 3'd0);
    chk_en = 1'b1;

    // write 01/00/1140
    phy_present = 1'b0;
    start_req(1'b0, 5'h01, 5'h00, 16'h1140, 1'b0);
    wait_done(rel);
    chk("wr_done_cycle", rel, 385);
    get_cap(v, n_bits, n_oe);
    chk("wr_nbits", n_bits, 64);
    chk("wr_pre_bits", v[63:32], 32'hFFFFFFFF);
    chk("wr_frame_bits", v[31:0], 32'h50821140);
    chk("wr_oe_bits", n_oe, 64);

    // read 1F/02 with PHY returning 0141
    phy_present = 1'b1;
    phy_data    = 16'h0141;
    start_req(1'b1, 5'h1F, 5'h02, 16'hDEAD, 1'b0);
    wait_done(rel);
    chk("rd_done_cycle", rel, 385);
    chk("rd_data_0141", rd_data, 16'h0141);
    chk("rd_err_phy", rd_err, 1'b0);
    get_cap(v, n_bits, n_oe);
    chk("rd_oe_low_bits", 64 - n_oe, 18);
    chk("rd_cmd_bits", v[31:18], 14'h1BE2);

    // read with no PHY on the bus
    phy_present = 1'b0;
    start_req(1'b1, 5'h05, 5'h03, 16'h0000, 1'b0);
    wait_done(rel);
    chk("nophy_done_cycle", rel, 385);
    chk("nophy_rd_data", rd_data, 16'hFFFF);
    chk("nophy_rd_err", rd_err, 1'b1);

    // back-to-back write then read, req_valid held high
    start_req(1'b0, 5'h02, 5'h01, 16'h0F0F, 1'b1);
    req_rd = 1'b1; req_phyad = 5'h03; req_regad = 5'h1E; req_wdata = 16'h5555;
    phy_present = 1'b1;
    phy_data    = 16'hBEEF;
    wait_done(rel);
    chk("b2b_first_done", rel, 385);
    d1 = cyc;
    rdy_cnt = 0;
    rise = -1;
    for (int i = 0; i < 20 && rise < 0; i++) begin
      @(negedge clk);
      if (req_ready === 1'b1) rdy_cnt++;
      if (mdc === 1'b1) rise = cyc;
    end
    req_valid = 1'b0;
    chk("b2b_ready_cycles", rdy_cnt, 1);
    // second frame's first low phase at d1+2, so its first MDC rise is H cycles later
    chk("b2b_first_rise", rise - d1, 2 + H);
    accept_cyc = d1 + 2;
    wait_done(rel2);
    chk("b2b_second_done", rel2, 385);
    chk("b2b_rd_data", rd_data, 16'hBEEF);
    chk("b2b_rd_err", rd_err, 1'b0);

    // reset during cycle 100 of a read
    phy_data = 16'h1234;
    start_req(1'b1, 5'h07, 5'h09, 16'h0000, 1'b0);
    repeat (99) @(posedge clk);
    #2 reset_n = 1'b0;
    @(posedge clk);
    #2 reset_n = 1'b1;
    @(negedge clk);
    chk("mid_rst_ready", req_ready, 1'b1);
    chk("mid_rst_done", done, 1'b0);
    chk("mid_rst_mdc", mdc, 1'b0);
    chk("mid_rst_oe", mdio_oe, 1'b0);
    chk("mid_rst_o", mdio_o, 1'b1);
    chk("mid_rst_rd_data", rd_data, 16'h0000);
    dcnt = 0;
    repeat (450) begin
      @(negedge clk);
      if (done === 1'b1) dcnt++;
    end
    chk("mid_rst_no_done", dcnt, 0);
    phy_present = 1'b0;
    start_req(1'b0, 5'h01, 5'h00, 16'h1140, 1'b0);
    wait_done(rel);
    chk("post_rst_done_cycle", rel, 385);
    get_cap(v, n_bits, n_oe);
    chk("post_rst_pre_bits", v[63:32], 32'hFFFFFFFF);
    chk("post_rst_frame_bits", v[31:0], 32'h50821140);

    // MDC_HALF=2, PRE_LEN=0 instance
    @(posedge clk); #2;
    chk("d2_idle_ready", req_ready2, 1'b1);
    chk("d2_idle_state", dbg_state2, 3'd0);
    cap2_o.delete(); cap2_oe.delete(); rise2_q.delete();
    req_rd = 1'b0; req_phyad = 5'h01; req_regad = 5'h00; req_wdata = 16'h1140;
    req_valid2 = 1'b1;
    @(posedge clk); #1;
    a2 = cyc;
    #1 req_valid2 = 1'b0;
    rel = -1;
    for (int i = 0; i < 400 && rel < 0; i++) begin
      @(negedge clk);
      if (done2 === 1'b1) rel = cyc - a2 + 1;
    end
    if (rel < 0) timeout("d2_done");
    chk("d2_done_cycle", rel, 129);
    v2 = '0;
    n_oe = 0;
    for (int i = 0; i < cap2_o.size(); i++) begin
      v2 = {v2[30:0], cap2_o[i]};
      if (cap2_oe[i]) n_oe++;
    end
    chk("d2_nbits", cap2_o.size(), 32);
    chk("d2_frame_bits", v2, 32'h50821140);
    chk("d2_oe_bits", n_oe, 32);
    if (rise2_q.size() >= 2) chk("d2_mdc_period", rise2_q[1] - rise2_q[0], 4);
    else timeout("d2_mdc_rises");

    repeat (3) @(posedge clk);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/mdio_master.md
MDIO_MASTER -- requirements
Module: mdio_master

Interface
REQ-001 Parameter MDC_HALF, default 3, clk cycles per MDC half-period; legal range 2..63; MDC = 12.5 MHz / (2*MDC_HALF), 2.08 MHz at default.
REQ-002 Parameter PRE_LEN, default 32, number of preamble 1-bits per frame; legal range 0..32.
REQ-003 clk_12m_5_mdio  in  1  sole clock: the 12.5 MHz MDIO clock from the PLL; all logic rises on it.
REQ-004 reset_n  in  1  synchronous, active-low reset.
REQ-005 req_valid  in  1  management request present.
REQ-006 req_ready  out  1  block idle; a request is accepted when req_valid and req_ready are both 1 on a clock edge.
REQ-007 req_rd  in  1  1 = Clause 22 read (OP=10); 0 = write (OP=01).
REQ-008 req_phyad  in  5  PHY address.
REQ-009 req_regad  in  5  register address.
REQ-010 req_wdata  in  16  write data; ignored for reads.
REQ-011 done  out  1  one-cycle pulse when a transaction completes.
REQ-012 rd_data  out  16  read result; valid from the done pulse of a read until the next read's done pulse.
REQ-013 rd_err  out  1  valid with done on reads; 1 = PHY did not drive the TA zero bit.
REQ-014 mdc  out  1  management data clock to the PHYs.
REQ-015 mdio_o, mdio_oe  out  1, 1  MDIO output value and output enable for the pad tristate.
REQ-016 mdio_i  in  1  MDIO pad input; already synchronised externally.

Function
REQ-017 Request fields shall be captured on acceptance; input changes after acceptance shall not affect the frame.
REQ-018 req_ready shall be 1 only in IDLE; it shall drop on the cycle after acceptance.
REQ-019 Frame bit order, MSB first: PRE_LEN x 1, ST=01, OP, PHYAD[4:0], REGAD[4:0], TA, DATA[15:0]; total PRE_LEN+32 bits.
REQ-020 Each bit period shall be 2*MDC_HALF clocks: mdc low for MDC_HALF cycles, then high for MDC_HALF cycles.
REQ-021 The first low phase shall begin on the cycle after acceptance.
REQ-022 mdio_o/mdio_oe shall change only at the start of a low phase, i.e. the cycle mdc goes or stays 0 at a bit boundary.
REQ-023 mdio_i shall be sampled on the clock edge at which mdc goes 0->1.
REQ-024 Writes: mdio_oe=1 for all bits; TA=10; DATA=req_wdata.
REQ-025 Reads: mdio_oe=1 through REGAD; mdio_oe=0 for both TA bits and all 16 DATA bits; the 16 DATA samples shall shift into rd_data MSB first.
REQ-026 Reads: rd_err shall be 1 if the second TA sample is 1; the frame still runs to completion.
REQ-027 FSM states: IDLE -> PRE (skipped if PRE_LEN=0) -> CMD (14 bits: ST, OP, PHYAD, REGAD) -> TA (2 bits) -> DATA (16 bits) -> DONE -> IDLE.
REQ-028 DONE shall last exactly one cycle, in which done=1; it shall be entered on the cycle after the last high phase of DATA ends.
REQ-029 done shall pulse at 1 + (PRE_LEN+32)*2*MDC_HALF cycles after the accept edge; this is 385 at defaults.
REQ-030 req_ready shall return to 1 on the cycle after done; back-to-back requests are legal, with no extra gap.
REQ-031 In IDLE and DONE: mdc=0, mdio_oe=0, mdio_o=1.
REQ-032 Bit and half-period counters shall be sized for the parameter maxima; no wrap-around inside a frame.

Reset
REQ-033 When reset_n=0 on a clock edge: state=IDLE, req_ready=1 (from the following cycle onward), done=0, rd_err=0, rd_data=16'h0000, mdc=0, mdio_oe=0, mdio_o=1.
REQ-034 Reset mid-frame shall abort with no done pulse and discard the captured request; the next request after release shall produce a full frame including the preamble.

Verification
REQ-035 Write phyad=5'h01, regad=5'h00, wdata=16'h1140 at defaults -> the mdio_o sample at each mdc rise reads 32x1, 01 01 00001 00000 10 0001000101000000; mdio_oe=1 throughout; done at cycle 385.
REQ-036 Read phyad=5'h1F, regad=5'h02, PHY model drives TA 0 and data 16'h0141 -> mdio_oe=0 for the last 18 bits; rd_data=16'h0141; rd_err=0 with done.
REQ-037 Read with mdio_i held at 1 (no PHY) -> rd_data=16'hFFFF, rd_err=1; done still at cycle 385.
REQ-038 Back-to-back write then read with req_valid held high -> second frame's first mdc low starts two cycles after the first done; req_ready is 1 for exactly one cycle between frames.
REQ-039 reset_n=0 at cycle 100 of a read -> outputs match REQ-033 on the next cycle; no done pulse; a following write completes normally.
REQ-040 MDC_HALF=2, PRE_LEN=0 -> frame is 32 bits; mdc period is 4 clocks; done at cycle 129 after accept.
